cs_out_buf: RTL and testbench
=============================

CS_OUT_BUF -- requirements
Module: cs_out_buf

Interface
REQ-001 Parameter WARMUP, default 9: posedges after reset release during which Y is not yet valid and is discarded.
REQ-002 Parameter DEPTH, default 16: FIFO entries, power of two.
REQ-003 Parameter N_OUT, default 1992: total Y capture attempts per run.
REQ-004 Port clk  input  1: single clock; all state changes on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 Port Y  input  10: CS result word, updated once per cycle after the posedge.
REQ-007 Port out_data  output  10: head-of-FIFO word.
REQ-008 Port out_valid  output  1: out_data holds a valid word.
REQ-009 Port out_ready  input  1: consumer accepts the word; a transfer occurs on a posedge with out_valid=1 and out_ready=1.
REQ-010 Port overflow  output  1: sticky; set when a capture is dropped.
REQ-011 Port drop_cnt  output  16: dropped-capture count, saturating at 16'hFFFF.
REQ-012 Port done  output  1: all N_OUT attempts made and FIFO drained.

Function
REQ-013 FSM states SHALL be WARMUP, STREAM and DONE; reset enters WARMUP.
REQ-014 WARMUP SHALL count posedges after reset release and SHALL enter STREAM on the WARMUP-th posedge.
REQ-015 In STREAM, every posedge SHALL be a capture attempt sampling Y; the first attempt is posedge WARMUP+1.
REQ-016 A capture attempt SHALL push Y if the FIFO is not full, or if it is full and a pop occurs on the same edge.
REQ-017 A capture attempt on a full FIFO without a same-edge pop SHALL drop Y, set overflow and increment drop_cnt (saturating).
REQ-018 An attempt counter SHALL count pushed and dropped captures; the N_OUT-th attempt SHALL move the FSM to DONE.
REQ-019 DONE SHALL make no further captures and SHALL continue to serve pops.
REQ-020 Pushing into an empty FIFO SHALL raise out_valid on the following cycle, with no same-cycle bypass.
REQ-021 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 A pop on an empty FIFO SHALL be impossible: out_ready with out_valid=0 is ignored.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-024 done SHALL be 1 exactly when state=DONE and the FIFO is empty; it is a registered output.
REQ-025 Data SHALL pass unmodified and in capture order; no arithmetic is applied to Y.

Reset
REQ-026 While reset=0: out_data=0, out_valid=0, overflow=0, drop_cnt=0, done=0, FIFO empty, counters 0, state WARMUP.
REQ-027 Reset asserted mid-STREAM or mid-DONE SHALL discard FIFO contents immediately; after release the block SHALL restart WARMUP from 0.

Structure
REQ-028 Package cs_pkg SHALL hold Y_W=10, X_W=8, CNT_W=16 and the FSM state enum.
REQ-029 Sub-module cs_fifo (synchronous FIFO, DEPTH x Y_W, push/pop/full/empty) SHALL be instantiated once; FSM and counters are in cs_out_buf.

Verification
REQ-030 Release reset; Y = 10'h100+cycle; out_ready=1: first out_data equals Y sampled at posedge 10; subsequent words increment by 1 with no gaps.
REQ-031 out_ready=0 for 20 STREAM cycles: 16 words stored; overflow=1 and drop_cnt=4; on raising out_ready, the 16 stored words emerge in order.
REQ-032 FIFO full, out_ready=1 on an attempt edge: pop and push both occur; drop_cnt is unchanged.
REQ-033 N_OUT=20, out_ready=1: exactly 20 words are delivered; done=1 the cycle after the last pop; Y changes afterwards produce no output.
REQ-034 Assert reset for 3 cycles mid-STREAM with 5 words queued: out_valid=0 immediately; after release, the first word again comes from posedge 10 after release.
REQ-035 Random out_ready at 50% over 2000 cycles: the delivered sequence equals captured Y minus drops; out_data is held stable whenever a word is stalled.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared widths and FSM state encoding for the CS output buffer.
// Y_W is derived from the CS input width plus two bits of result growth.
package cs_pkg;
  localparam int X_W   = 8;
  localparam int Y_W   = X_W + 2;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } cs_state_t;
endpackage

// File: rtl/cs_fifo.sv
// Synchronous DEPTH x Y_W FIFO. The pointers carry one extra wrap bit so
// that full and empty can be told apart.
module cs_fifo
  import cs_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [Y_W-1:0] wdata,
  output logic [Y_W-1:0] rdata,
  output logic           full,
  output logic           empty,
  output logic [AW:0]    count
);
  logic [Y_W-1:0] mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic           do_push;
  logic           do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The head reads as zero while nothing is stored, so reset shows a clean zero.
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/cs_out_buf.sv
// Output buffer for CS results: discards the warm-up words, then captures one Y
// per cycle into a FIFO for a valid/ready consumer until N_OUT attempts are made.
module cs_out_buf
  import cs_pkg::*;
#(
  parameter int WARMUP = 9,
  parameter int DEPTH  = 16,
  parameter int N_OUT  = 1992
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Y_W-1:0]   Y,
  output logic [Y_W-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             done,
  output logic [1:0]       state_dbg
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: a word moves on a rising edge where out_valid and out_ready are
  // both 1; out_data/out_valid hold while stalled and out_ready alone does nothing.
  cs_state_t        state;
  logic [CNT_W-1:0] wu_cnt;
  logic [CNT_W-1:0] att_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic [AW:0]      count_next;
  logic             attempt;
  logic             pop;
  logic             push;
  logic             drop;
  logic             last_attempt;

  assign attempt      = (state == ST_STREAM);
  assign pop          = out_ready && !fifo_empty;
  assign push         = attempt && (!fifo_full || pop);
  assign drop         = attempt && fifo_full && !pop;
  assign last_attempt = attempt && (att_cnt == CNT_W'(N_OUT - 1));
  assign count_next   = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign out_valid = !fifo_empty;
  assign state_dbg = state;

  cs_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (Y),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_WARMUP;
      wu_cnt   <= '0;
      att_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_WARMUP: begin
          if (wu_cnt == CNT_W'(WARMUP - 1)) state <= ST_STREAM;
          else                              wu_cnt <= wu_cnt + 1'b1;
        end
        ST_STREAM: begin
          if (last_attempt) state   <= ST_DONE;
          else              att_cnt <= att_cnt + 1'b1;
        end
        ST_DONE: ;
        default: state <= ST_WARMUP;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
      end

      // done looks ahead at this edge's FIFO movement so it rises with the last pop.
      done <= ((state == ST_DONE) || last_attempt) && (count_next == '0);
    end
  end
endmodule

// File: tb/tb_cs_out_buf.sv
// Bench for cs_out_buf: two instances (default N_OUT and N_OUT=20) driven in
// lockstep and checked every cycle against a queue-based model of the buffer.
module tb_cs_out_buf;
  import cs_pkg::*;

  localparam int WU = 9;
  localparam int DP = 16;
  localparam int N0 = 1992;
  localparam int N1 = 20;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [Y_W-1:0] y = '0;
  logic           out_ready = 1'b0;

  logic [Y_W-1:0]   od0, od1;
  logic             ov0, ov1, of0, of1, dn0, dn1;
  logic [CNT_W-1:0] dc0, dc1;
  logic [1:0]       st0, st1;

  always #5 clk = ~clk;

  cs_out_buf #(.WARMUP(WU), .DEPTH(DP), .N_OUT(N0)) dut (
    .clk(clk), .reset(reset), .Y(y), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .overflow(of0), .drop_cnt(dc0), .done(dn0), .state_dbg(st0)
  );

  cs_out_buf #(.WARMUP(WU), .DEPTH(DP), .N_OUT(N1)) dut_n (
    .clk(clk), .reset(reset), .Y(y), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .overflow(of1), .drop_cnt(dc1), .done(dn1), .state_dbg(st1)
  );

  // Model: edge index since release, one queue of captured words per instance.
  logic [Y_W-1:0] exp_q [2][$];
  int             edge_n = 0;
  bit             m_of [2];
  int             m_drop [2];
  int             xfer1 = 0;
  int             total = 0;
  int             bad = 0;

  function automatic int nout(input int i);
    return (i == 0) ? N0 : N1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t edge=%0d)", name, act, exp, $time, edge_n);
    end
  endtask

  task automatic model_clear();
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      m_of[i]   = 1'b0;
      m_drop[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit pop;
    bit att;
    if (!reset) begin
      model_clear();
      return;
    end
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      pop = (exp_q[i].size() > 0) && out_ready;
      att = (edge_n > WU) && (edge_n <= WU + nout(i));
      if (att) begin
        if (exp_q[i].size() < DP || pop) exp_q[i].push_back(y);
        else begin
          m_of[i] = 1'b1;
          if (m_drop[i] < 65535) m_drop[i]++;
        end
      end
      if (pop) void'(exp_q[i].pop_front());
    end
  endtask

  task automatic compare();
    logic [Y_W-1:0] e_data;
    logic           e_valid;
    logic           e_done;
    for (int i = 0; i < 2; i++) begin
      e_valid = (exp_q[i].size() > 0);
      e_data  = e_valid ? exp_q[i][0] : '0;
      e_done  = reset && (edge_n >= WU + nout(i)) && !e_valid;
      if (i == 0) begin
        check("valid0", 32'(ov0), 32'(e_valid));
        check("data0", 32'(od0), 32'(e_data));
        check("ovf0", 32'(of0), 32'(m_of[0]));
        check("drop0", 32'(dc0), 32'(m_drop[0]));
        check("done0", 32'(dn0), 32'(e_done));
      end else begin
        check("valid1", 32'(ov1), 32'(e_valid));
        check("data1", 32'(od1), 32'(e_data));
        check("ovf1", 32'(of1), 32'(m_of[1]));
        check("drop1", 32'(dc1), 32'(m_drop[1]));
        check("done1", 32'(dn1), 32'(e_done));
      end
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are compared there too.
  task automatic tick();
    if (reset && ov1 && out_ready) xfer1++;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    model_clear();
    #1;
    compare();
    check("rst_valid", 32'(ov0), 32'd0);
    check("rst_data", 32'(od0), 32'd0);
    repeat (cycles) tick();
    reset = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    check("reset_state", 32'(st0), 32'(ST_WARMUP));
    check("reset_drop", 32'(dc0), 32'd0);
    check("reset_done", 32'(dn0), 32'd0);
    reset = 1'b1;

    // Counting Y with a ready consumer: first word is Y from edge 10.
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      y = Y_W'(10'h100 + edge_n + 1);
      tick();
      if (edge_n == 10) check("first_word", 32'(od0), 32'h10A);
      if (edge_n == 29) check("n20_not_done", 32'(dn1), 32'd0);
      if (edge_n == 30) check("n20_done", 32'(dn1), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      y = Y_W'($urandom);
      tick();
    end
    check("n20_delivered", 32'(xfer1), 32'd20);
    check("n20_state", 32'(st1), 32'(ST_DONE));

    // Stalled consumer for 20 attempts: 16 stored, 4 dropped.
    do_reset(2);
    out_ready = 1'b0;
    while (edge_n < WU + 20) begin
      y = Y_W'($urandom);
      tick();
    end
    check("stall_drop", 32'(dc0), 32'd4);
    check("stall_ovf", 32'(of0), 32'd1);
    out_ready = 1'b1;
    y = Y_W'($urandom);
    tick();
    check("full_pop_push", 32'(dc0), 32'd4);
    for (int k = 0; k < 30; k++) begin
      y = Y_W'($urandom);
      tick();
    end

    // Reset mid-stream with 5 words queued, then restart from warm-up.
    do_reset(0);
    out_ready = 1'b0;
    while (edge_n < WU + 5) begin
      y = Y_W'($urandom);
      tick();
    end
    check("five_queued", 32'(ov0), 32'd1);
    do_reset(3);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      y = Y_W'(10'h100 + edge_n + 1);
      tick();
      if (edge_n == 10) check("restart_word", 32'(od0), 32'h10A);
    end

    // Random consumer over a full default-length run, then drain.
    do_reset(2);
    for (int k = 0; k < 2005; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      y = Y_W'($urandom);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      y = Y_W'($urandom);
      tick();
    end
    check("run_done", 32'(dn0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
